// File: rtl/mp_data_memory.sv
// Shared N-port word memory for the matrix-multiply core array: per-port read/write,
// write-limit protection, fixed-priority collision resolution and a built-in clear engine.
module mp_data_memory #(
  parameter int NUM_PORTS = 8,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 10501
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          wr_en,
  input  logic [NUM_PORTS-1:0]          rd_en,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
  output logic [NUM_PORTS*DATA_W-1:0]   rdata,
  output logic [NUM_PORTS-1:0]          rvalid,
  input  logic                          limit_ld,
  input  logic [ADDR_W:0]               limit_in,
  input  logic                          clr_req,
  output logic                          busy,
  output logic [NUM_PORTS-1:0]          wr_err,
  output logic [NUM_PORTS-1:0]          rd_err,
  input  logic                          err_clr
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]    DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                   state_reg, state_next;
  logic [IDX_W-1:0]         ptr_reg, ptr_next;
  logic [ADDR_W:0]          limit_reg;
  logic [DATA_W-1:0]        mem [DEPTH];
  logic                     idle;

  logic [ADDR_W-1:0]        port_addr  [NUM_PORTS];
  logic [DATA_W-1:0]        port_wdata [NUM_PORTS];
  logic [IDX_W-1:0]         port_idx   [NUM_PORTS];
  logic [NUM_PORTS-1:0]     addr_ok, wr_ok, wr_acc, wr_rej, rd_acc, rd_oob;

  logic [NUM_PORTS*DATA_W-1:0] rdata_reg;
  logic [NUM_PORTS-1:0]        rvalid_reg, wr_err_reg, rd_err_reg;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= CLEAR;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  // FSM next state: a clear request while already clearing does not restart the sweep
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (clr_req) begin
          state_next = CLEAR;
          ptr_next   = '0;
        end
      end
      CLEAR: begin
        if (ptr_reg == LAST_IDX) begin
          state_next = IDLE;
          ptr_next   = '0;
        end else begin
          ptr_next = ptr_reg + 1'b1;
        end
      end
      default: begin
        state_next = CLEAR;
        ptr_next   = '0;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_reg == CLEAR);
    idle = (state_reg == IDLE);
  end

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic hit;

      assign port_addr[gi]  = addr[gi*ADDR_W +: ADDR_W];
      assign port_wdata[gi] = wdata[gi*DATA_W +: DATA_W];
      assign port_idx[gi]   = port_addr[gi][IDX_W-1:0];
      assign addr_ok[gi]    = ({1'b0, port_addr[gi]} < DEPTH_W);
      assign wr_ok[gi]      = idle && wr_en[gi] && addr_ok[gi] &&
                              ({1'b0, port_addr[gi]} < limit_reg);

      // Any lower port with an in-range write to the same word wins; the lowest such
      // port is necessarily the accepted one, so no chained dependency is needed.
      always_comb begin
        hit = 1'b0;
        for (int q = 0; q < gi; q++) begin
          if (wr_ok[q] && (port_addr[q] == port_addr[gi])) hit = 1'b1;
        end
      end

      assign wr_acc[gi] = wr_ok[gi] && !hit;
      assign wr_rej[gi] = idle && wr_en[gi] && !wr_acc[gi];
      assign rd_acc[gi] = idle && rd_en[gi];
      assign rd_oob[gi] = rd_acc[gi] && !addr_ok[gi];
    end
  endgenerate

  // Array write side: clear sweep or accepted port writes (mutually exclusive by state)
  always_ff @(posedge clk) begin
    if (state_reg == CLEAR) mem[ptr_reg] <= '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (wr_acc[p]) mem[port_idx[p]] <= port_wdata[p];
    end
  end

  // Read-first registered reads, write limit and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg  <= '0;
      rvalid_reg <= '0;
      wr_err_reg <= '0;
      rd_err_reg <= '0;
      limit_reg  <= DEPTH_W;
    end else begin
      rvalid_reg <= rd_acc;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (rd_acc[p]) begin
          rdata_reg[p*DATA_W +: DATA_W] <= addr_ok[p] ? mem[port_idx[p]] : '0;
        end
      end
      if (limit_ld) limit_reg <= (limit_in > DEPTH_W) ? DEPTH_W : limit_in;
      wr_err_reg <= (err_clr ? '0 : wr_err_reg) | wr_rej;
      rd_err_reg <= (err_clr ? '0 : rd_err_reg) | rd_oob;
    end
  end

  assign rdata  = rdata_reg;
  assign rvalid = rvalid_reg;
  assign wr_err = wr_err_reg;
  assign rd_err = rd_err_reg;

endmodule

// File: tb/tb_mp_data_memory.sv
// Directed bench for mp_data_memory (DEPTH=16, 8 ports): expected reads are queued when
// issued and compared when rvalid returns; flags and busy timing are checked inline.
module tb_mp_data_memory;
  localparam int NP = 8;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int DEPTH = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NP-1:0]      wr_en, rd_en;
  logic [NP*AW-1:0]   addr;
  logic [NP*DW-1:0]   wdata;
  logic [NP*DW-1:0]   rdata;
  logic [NP-1:0]      rvalid;
  logic               limit_ld;
  logic [AW:0]        limit_in;
  logic               clr_req;
  logic               busy;
  logic [NP-1:0]      wr_err, rd_err;
  logic               err_clr;

  typedef struct {
    int          port;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cnt;

  mp_data_memory #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .limit_ld(limit_ld),
    .limit_in(limit_in), .clr_req(clr_req), .busy(busy), .wr_err(wr_err),
    .rd_err(rd_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    wr_en = '0; rd_en = '0; addr = '0; wdata = '0;
    limit_ld = 1'b0; limit_in = '0; clr_req = 1'b0; err_clr = 1'b0;
  endtask

  task automatic wr(input int p, input logic [15:0] a, input logic [15:0] d);
    wr_en[p] = 1'b1;
    addr[p*AW +: AW] = a;
    wdata[p*DW +: DW] = d;
  endtask

  task automatic rd(input int p, input logic [15:0] a, input logic [15:0] d, input bit expect_data);
    exp_t e;
    rd_en[p] = 1'b1;
    addr[p*AW +: AW] = a;
    if (expect_data) begin
      e.port = p;
      e.data = d;
      sb.push_back(e);
    end
  endtask

  // Apply current inputs for one clock, then compare the read results they produced.
  task automatic cycle();
    logic [NP-1:0] mask;
    exp_t e;
    mask = '0;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mask[e.port] = 1'b1;
      check($sformatf("rdata p%0d", e.port), 32'(rdata[e.port*DW +: DW]), 32'(e.data));
    end
    check("rvalid", 32'(rvalid), 32'(mask));
    $display("cycle t=%0t rvalid=%h wr_err=%h rd_err=%h busy=%0b", $time, rvalid, wr_err, rd_err, busy);
    clear_inputs();
  endtask

  task automatic count_busy(input string tag);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      cycle();
    end
    check(tag, 32'(cnt), 32'(DEPTH));
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset rdata", 32'(rdata == '0), 32'd1);
    check("reset rvalid", 32'(rvalid), 32'd0);
    check("reset wr_err", 32'(wr_err), 32'd0);
    check("reset rd_err", 32'(rd_err), 32'd0);
    check("reset busy", 32'(busy), 32'd1);
    rst_n = 1'b1;
    count_busy("reset busy cycles");

    // Everything reads zero after the initial clear
    for (int b = 0; b < 2; b++) begin
      for (int p = 0; p < NP; p++) rd(p, 16'(b*NP + p), 16'h0000, 1'b1);
      cycle();
    end
    cycle();
    check("no wr_err after clear", 32'(wr_err), 32'd0);
    check("no rd_err after clear", 32'(rd_err), 32'd0);

    // Broadcast a single write
    wr(0, 16'd5, 16'h1234);
    cycle();
    for (int p = 0; p < NP; p++) rd(p, 16'd5, 16'h1234, 1'b1);
    cycle();

    // Same-address collision: port 2 beats port 6
    wr(2, 16'd9, 16'hAAAA);
    wr(6, 16'd9, 16'hBBBB);
    cycle();
    check("collision wr_err", 32'(wr_err), 32'h40);
    rd(4, 16'd9, 16'hAAAA, 1'b1);
    cycle();
    err_clr = 1'b1;
    cycle();
    check("err_clr wr_err", 32'(wr_err), 32'd0);

    // Write limit
    limit_ld = 1'b1;
    limit_in = 17'd10;
    cycle();
    wr(3, 16'd10, 16'h7777);
    cycle();
    check("limit reject", 32'(wr_err), 32'h08);
    wr(3, 16'd9, 16'h9999);
    cycle();
    check("limit accept sticky", 32'(wr_err), 32'h08);
    rd(0, 16'd10, 16'h0000, 1'b1);
    rd(1, 16'd9, 16'h9999, 1'b1);
    cycle();
    err_clr = 1'b1;
    cycle();

    // Read-first behaviour and out-of-range reads
    rd(1, 16'd4, 16'h0000, 1'b1);
    wr(0, 16'd4, 16'h5555);
    cycle();
    rd(1, 16'd4, 16'h5555, 1'b1);
    cycle();
    rd(1, 16'(DEPTH), 16'h0000, 1'b1);
    cycle();
    check("rd_err oob", 32'(rd_err), 32'h02);
    err_clr = 1'b1;
    rd(2, 16'd40, 16'h0000, 1'b1);
    cycle();
    check("err vs err_clr", 32'(rd_err), 32'h04);
    check("wr_err clean", 32'(wr_err), 32'd0);
    err_clr = 1'b1;
    cycle();
    check("rd_err cleared", 32'(rd_err), 32'd0);

    // Limit above DEPTH clamps to DEPTH
    limit_ld = 1'b1;
    limit_in = 17'd100;
    cycle();
    wr(5, 16'd15, 16'hC0DE);
    wr(7, 16'(DEPTH), 16'hDEAD);
    cycle();
    check("clamp wr_err", 32'(wr_err), 32'h80);
    rd(5, 16'd15, 16'hC0DE, 1'b1);
    cycle();
    err_clr = 1'b1;
    cycle();

    // Clear during traffic: accesses ignored, re-request ignored
    clr_req = 1'b1;
    cycle();
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      for (int p = 0; p < NP; p++) begin
        wr(p, 16'd1, 16'hFFFF);
        rd(p, (p == 0) ? 16'd50 : 16'd1, 16'h0000, 1'b0);
      end
      if (cnt == 5) clr_req = 1'b1;
      cycle();
    end
    check("clear busy cycles", 32'(cnt), 32'(DEPTH));
    check("busy wr_err", 32'(wr_err), 32'd0);
    check("busy rd_err", 32'(rd_err), 32'd0);
    for (int b = 0; b < 2; b++) begin
      for (int p = 0; p < NP; p++) rd(p, 16'(b*NP + p), 16'h0000, 1'b1);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
